// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with glitch-free divisor updates
// and a lock indicator that tracks settling of every enabled channel.
module clk_div_multi #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int DIV_INIT     = 32,
  parameter int LOCK_PERIODS = 2,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  typedef enum logic {
    SETTLE,
    LOCKED
  } lock_t;

  localparam logic [CH_W:0] NCH = NUM_CH[CH_W:0];
  localparam logic [3:0]    LP  = LOCK_PERIODS[3:0];

  lock_t state, state_n;

  logic [CNT_W-1:0] cnt   [NUM_CH];
  logic [CNT_W-1:0] cnt_n [NUM_CH];
  logic [CNT_W-1:0] div   [NUM_CH];
  logic [CNT_W-1:0] div_n [NUM_CH];
  logic [3:0]       lcnt  [NUM_CH];
  logic [3:0]       lcnt_n[NUM_CH];

  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] done;

  logic             pending;
  logic             pending_n;
  logic [CH_W-1:0]  pend_ch;
  logic [CNT_W-1:0] pend_div;

  logic accept;
  logic bad;
  logic good;
  logic restart;

  always_comb begin
    accept = cfg_valid & cfg_ready;
    bad    = ({1'b0, cfg_ch} >= NCH) ||
             (cfg_div < CNT_W'(2));
    good   = accept & ~bad;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]  = run[i] &&
                 (cnt[i] == div[i] - CNT_W'(1));
      apply[i] = pending &&
                 (pend_ch == CH_W'(i)) &&
                 (!run[i] || wrap[i]);
      div_n[i] = apply[i] ? pend_div : div[i];
      if (!ch_en[i] || !run[i] || wrap[i])
        cnt_n[i] = '0;
      else
        cnt_n[i] = cnt[i] + CNT_W'(1);
      lcnt_n[i] = lcnt[i];
      if (wrap[i] && lcnt[i] < LP)
        lcnt_n[i] = lcnt[i] + 4'd1;
      done[i] = !run[i] || (lcnt_n[i] >= LP);
    end
    // A divisor taking effect also restarts the period count,
    // so lock waits for full periods at the new divisor.
    restart   = good | (ch_en != run) | (|apply);
    pending_n = good ? 1'b1 :
                (|apply) ? 1'b0 : pending;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      SETTLE:
        if (!restart && (|run) && (&done))
          state_n = LOCKED;
      LOCKED:
        if (restart)
          state_n = SETTLE;
      default:
        state_n = SETTLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) state <= SETTLE;
    else     state <= state_n;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge refclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        cnt[i]    <= '0;
        div[i]    <= CNT_W'(DIV_INIT);
        lcnt[i]   <= '0;
        run[i]    <= 1'b0;
        outclk[i] <= 1'b0;
        tick[i]   <= 1'b0;
      end else begin
        cnt[i]    <= cnt_n[i];
        div[i]    <= div_n[i];
        lcnt[i]   <= restart ? 4'd0 : lcnt_n[i];
        run[i]    <= ch_en[i];
        outclk[i] <= ch_en[i] &&
                     (cnt_n[i] < (div_n[i] >> 1));
        tick[i]   <= ch_en[i] && (cnt_n[i] == '0);
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      pending   <= 1'b0;
      pend_ch   <= '0;
      pend_div  <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      pending   <= pending_n;
      cfg_ready <= ~pending_n;
      cfg_err   <= accept & bad;
      if (good) begin
        pend_ch  <= cfg_ch;
        pend_div <= cfg_div;
      end
    end
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent divider channels; legal range 2..8.
REQ-002 Parameter CNT_W, default 16, width of the divisor and the per-channel counter.
REQ-003 Parameter DIV_INIT, default 32, reset divisor for every channel; legal range 2..2^CNT_W-1.
REQ-004 Parameter LOCK_PERIODS, default 2, completed periods per enabled channel required before lock; legal range 1..15.
REQ-005 refclk  in  1  sole clock; all logic is rising-edge triggered.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ch_en  in  NUM_CH  per-channel run enable.
REQ-008 cfg_valid  in  1  divisor update request.
REQ-009 cfg_ch  in  clog2(NUM_CH)  target channel of the update.
REQ-010 cfg_div  in  CNT_W  new divisor D, in refclk cycles per output period.
REQ-011 cfg_ready  out  1  update can be accepted.
REQ-012 cfg_err  out  1  one-cycle pulse when an update is rejected.
REQ-013 outclk  out  NUM_CH  registered square-wave outputs.
REQ-014 tick  out  NUM_CH  registered one-cycle pulse at the start of each period.
REQ-015 locked  out  1  all enabled channels are stable.

Function
REQ-016 Each channel SHALL hold counter cnt and active divisor D; while enabled, cnt increments every cycle and wraps from D-1 to 0.
REQ-017 Outputs are registered so that in the cycle in which cnt==k: outclk=1 iff k < floor(D/2), and tick=1 iff k==0.
REQ-018 For odd D, the high phase is floor(D/2) cycles and the low phase is ceil(D/2) cycles.
REQ-019 While ch_en[i]=0, the channel SHALL hold cnt=0 with outclk[i]=0 and tick[i]=0.
REQ-020 On the first enabled cycle the channel presents cnt=0 outputs, i.e. tick=1 and outclk=1.
REQ-021 An update is accepted when cfg_valid=1 and cfg_ready=1.
REQ-022 An accepted cfg_div < 2 is rejected: cfg_err=1 in the next cycle, no state changes, and cfg_ready stays 1.
REQ-023 A legal update is held pending; cfg_ready=0 from the next cycle until the update is applied.
REQ-024 A pending update is applied in the target channel's wrap cycle (cnt==D-1 to 0), so the period in progress completes at the old D.
REQ-025 If the target channel is disabled, the pending update is applied in the next cycle.
REQ-026 cfg_ready returns to 1 in the cycle after the update is applied; at most one update is pending at any time.
REQ-027 Lock state machine: SETTLE to LOCKED when every enabled channel has completed LOCK_PERIODS periods (a period completes on a cycle with cnt==D-1) since entry to SETTLE; locked=1 in the following cycle.
REQ-028 The lock state machine requires at least one enabled channel to reach LOCKED.
REQ-029 LOCKED to SETTLE on any of: an update accepted, any ch_en bit changing, or ch_en becoming all-zero; locked=0 in the next cycle and period counts restart.
REQ-030 A rejected update SHALL NOT affect locked.
REQ-031 If ch_en changes in the same cycle that an update is accepted, one SETTLE entry occurs.

Reset
REQ-032 While rst=1 at a rising edge, the following take their reset values at that edge: all cnt=0, all D=DIV_INIT, outclk=0, tick=0, locked=0, cfg_err=0, cfg_ready=0, pending update cleared, lock state machine in SETTLE.
REQ-033 In the first cycle after rst deasserts, cfg_ready=1.
REQ-034 In the first cycle after rst deasserts, enabled channels start at cnt=0.
REQ-035 A rst during a pending update or during LOCKED discards the pending update and the lock.

Verification (NUM_CH=2, DIV_INIT=32, LOCK_PERIODS=2; cycle 0 = first cycle after reset)
REQ-036 ch_en=01 held -> tick[0] at cycles 0,32,64; outclk[0] high 16 cycles, low 16 cycles; outclk[1]=0; locked=1 from cycle 64.
REQ-037 Update ch1 with D=5 while ch1 is disabled, then enable ch1 -> outclk[1] repeats high 2 cycles, low 3 cycles; tick[1] every 5 cycles.
REQ-038 Locked, ch0 at cnt=10, update D=8 -> cfg_ready=0 and locked=0 next cycle; the old period ends at 32 cycles, the next periods are 8 cycles; cfg_ready=1 after the wrap; locked=1 after 2 new periods on every enabled channel.
REQ-039 cfg_div=1 -> cfg_err=1 for exactly one cycle; D, outputs and locked are unchanged.
REQ-040 rst pulse of 1 cycle mid-period with a pending update -> next cycle all outputs are at reset values, D=32, pending update dropped, re-lock at cycle 64 after release.
REQ-041 ch_en 11 -> 01 while locked -> outclk[1]=0 next cycle, locked=0 next cycle, re-lock after 2 ch0 periods.
